// File: rtl/seq_div16.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// with divide-by-zero resolved in a single cycle.
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               divisor_zero_s;
    logic               last_iter_s;

    // dvd_r shifts the dividend out of its MSB while quotient bits enter its LSB
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   rem_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               div_zero_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   rem_nxt_s;
    logic [WIDTH-1:0]   dvd_nxt_s;

    // Next-state and start acceptance
    always_comb begin
        state_nxt_s    = state_r;
        accept_s       = 1'b0;
        divisor_zero_s = (divisor == {WIDTH{1'b0}});
        last_iter_s    = (cnt_r == CW'(1));
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = divisor_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Single shared subtractor; a set MSB of the (WIDTH+1)-bit trial means borrow
    always_comb begin
        shifted_s = {rem_r, dvd_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        qbit_s    = ~trial_s[WIDTH];
        if (qbit_s) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
        end else begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
        end
        dvd_nxt_s = {dvd_r[WIDTH-2:0], qbit_s};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Status flags follow the state being entered, so they are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_RUN);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Working datapath and result registers; results only change at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            div_zero_r  <= 1'b0;
        end else if (accept_s) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= CW'(WIDTH);
            if (divisor_zero_s) begin
                quotient_r  <= {WIDTH{1'b1}};
                remainder_r <= dividend;
                div_zero_r  <= 1'b1;
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
                div_zero_r  <= div_zero_r;
            end
        end else if (state_r == ST_RUN) begin
            dvd_r <= dvd_nxt_s;
            rem_r <= rem_nxt_s;
            cnt_r <= cnt_r - CW'(1);
            if (last_iter_s) begin
                quotient_r  <= dvd_nxt_s;
                remainder_r <= rem_nxt_s;
                div_zero_r  <= 1'b0;
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
                div_zero_r  <= div_zero_r;
            end
        end else begin
            dvd_r       <= dvd_r;
            rem_r       <= rem_r;
            cnt_r       <= cnt_r;
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
            div_zero_r  <= div_zero_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: directed cases from the test plan plus
// randomized operands against an arithmetic reference model.
module tb_seq_div16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int          n_vec;
    int          n_err;
    int          edges;
    logic [15:0] last_q;
    logic [15:0] last_r;
    logic        last_dz;

    seq_div16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // advance one edge and sample 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // present a request for the next edge, then scramble the operand inputs
    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        edges    = 0;
        tick();
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // wait for done (bounded); previous results must stay visible meanwhile
    task automatic wait_done();
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1 && (quotient !== last_q || remainder !== last_r)) begin
                check_eq("hold_during_run", {quotient, remainder}, {last_q, last_r});
            end
            tick();
        end
    endtask

    task automatic check_result(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq;
        logic [15:0] er;
        int          elat;
        if (b == 16'd0) begin
            eq   = 16'hFFFF;
            er   = a;
            elat = 1;
        end else begin
            eq   = a / b;
            er   = a % b;
            elat = 17;
        end
        check_eq("latency", edges, elat);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("div_zero", div_zero, (b == 16'd0) ? 32'd1 : 32'd0);
        last_q  = eq;
        last_r  = er;
        last_dz = (b == 16'd0);
    endtask

    task automatic do_div(input logic [15:0] a, input logic [15:0] b);
        accept(a, b);
        check_eq("busy_after_accept", busy, (b == 16'd0) ? 32'd0 : 32'd1);
        wait_done();
        check_result(a, b);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec    = 0;
        n_err    = 0;
        edges    = 0;
        last_q   = 16'd0;
        last_r   = 16'd0;
        last_dz  = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {busy, done, div_zero, quotient, remainder}, 35'd0);
        rst = 1'b0;
        tick();

        // basic divide, then done must drop while results hold
        do_div(16'd100, 16'd7);
        tick();
        check_eq("done_drops", done, 1'b0);
        check_eq("hold_q_after_done", quotient, 16'd14);
        check_eq("hold_r_after_done", remainder, 16'd2);

        do_div(16'hFFFF, 16'd1);
        do_div(16'd3, 16'd10);
        tick();

        // divide-by-zero, then a normal divide clears the flag at completion
        do_div(16'd5, 16'd0);
        tick();
        check_eq("dz_hold", div_zero, 1'b1);
        check_eq("dz_done_drops", done, 1'b0);
        accept(16'd9, 16'd3);
        check_eq("dz_held_during_run", div_zero, 1'b1);
        wait_done();
        check_result(16'd9, 16'd3);
        tick();

        // start while busy is ignored
        accept(16'd1000, 16'd9);
        tick();
        tick();
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        tick();
        start    = 1'b0;
        wait_done();
        check_result(16'd1000, 16'd9);

        // start during the done cycle is accepted back-to-back
        do_div(16'd50, 16'd5);
        tick();

        // asynchronous reset mid-run
        accept(16'd40000, 16'd3);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset", {busy, done, div_zero, quotient, remainder}, 35'd0);
        last_q = 16'd0;
        last_r = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        accept(16'd40000, 16'd3);
        check_eq("busy_after_reset_start", busy, 1'b1);
        wait_done();
        check_result(16'd40000, 16'd3);

        // randomized operands with corner values, mixing back-to-back and idle gaps
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 9))
                0: ra = 16'd0;
                1: rb = 16'd0;
                2: rb = 16'd1;
                3: ra = 16'hFFFF;
                4: rb = 16'hFFFF;
                5: rb = (ra == 16'hFFFF) ? 16'hFFFF : ra + 16'($urandom_range(1, 16'hFFFF - ra));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                tick();
            end
            do_div(ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
